// File: rtl/line_mem_bridge.sv
// Cache line (4 x 32-bit) to word-bus bridge: serialises line fills and write-backs into four beats.
// Optional beat timeout when LINE_BRIDGE_TIMEOUT_EN is defined.
module line_mem_bridge (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  m_addr,
  input  logic [127:0] m_w_data,
  output logic [127:0] m_r_data,
  output logic         main_mem_ack,
  output logic         bus_req,
  output logic         bus_we,
  output logic [31:0]  bus_addr,
  output logic [31:0]  bus_wdata,
  input  logic         bus_ack,
  input  logic [31:0]  bus_rdata,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, BEAT, ACK, DROP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          op_we_q, op_we_d;
  logic [27:0]   addr_q, addr_d;
  logic [127:0]  wline_q, wline_d;
  logic [127:0]  rline_q, rline_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          timeout;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^m_addr[3:0];

`ifdef LINE_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counts BEAT cycles spent waiting on a requested beat; restarts at every beat issue.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || (state_q == BEAT && !bus_req_q)) cnt_d = '0;
    else if (state_q == BEAT && !bus_ack)                   cnt_d = cnt_q + 8'd1;
  end

  assign timeout = (state_q == BEAT) && bus_req_q && !bus_ack && (cnt_q == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    op_we_d     = op_we_q;
    addr_d      = addr_q;
    wline_d     = wline_q;
    rline_d     = rline_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ack_d       = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          op_we_d     = mem_write;
          addr_d      = m_addr[31:4];
          if (mem_write) wline_d = m_w_data;
          beat_d      = 2'd0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {m_addr[31:4], 4'b0000};
          bus_wdata_d = mem_write ? m_w_data[31:0] : 32'h0;
          err_d       = 1'b0;
          state_d     = BEAT;
        end
      end
      BEAT: begin
        if (!bus_req_q) begin
          // Gap cycle between beats: present the next beat registered.
          bus_req_d   = 1'b1;
          bus_addr_d  = {addr_q, beat_q, 2'b00};
          bus_wdata_d = op_we_q ? wline_q[{beat_q, 5'b0} +: 32] : 32'h0;
        end else if (bus_ack) begin
          if (!op_we_q) rline_d[{beat_q, 5'b0} +: 32] = bus_rdata;
          bus_req_d = 1'b0;
          if (beat_q == 2'd3) begin
            ack_d   = 1'b1;
            state_d = ACK;
          end else begin
            beat_d  = beat_q + 2'd1;
          end
        end else if (timeout) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          ack_d     = 1'b1;
          state_d   = ACK;
        end
      end
      ACK:  state_d = DROP;
      // Hold off until the cache has actually released its request.
      DROP: if (!mem_read && !mem_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      op_we_q     <= 1'b0;
      addr_q      <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      op_we_q     <= op_we_d;
      addr_q      <= addr_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign m_r_data     = rline_q;
  assign main_mem_ack = ack_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign err          = err_q;

endmodule

// File: tb/tb_line_mem_bridge.sv
// Scoreboard bench for line_mem_bridge: memory-model bus responder plus line-level reference model.
module tb_line_mem_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]  m_addr = '0;
  logic [127:0] m_w_data = '0;
  logic [127:0] m_r_data;
  logic         main_mem_ack, bus_req, bus_we, err;
  logic [31:0]  bus_addr, bus_wdata;
  logic         bus_ack = 1'b0;
  logic [31:0]  bus_rdata = '0;

  line_mem_bridge dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .m_addr(m_addr), .m_w_data(m_w_data), .m_r_data(m_r_data),
    .main_mem_ack(main_mem_ack), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct { logic [127:0] line; logic err; } resp_t;

  localparam int M_RAND = 0, M_ALWAYS = 1, M_DELAY = 2, M_NOB1 = 3;

  int checks = 0, errors = 0;
  int cyc = 0, ack_cnt = 0, last_ack_cyc = 0, req_run = 0, last_run = 0;
  int ack_mode = M_ALWAYS;
  bit rd_pattern = 1'b0;
  beat_t exp_beats[$];
  resp_t exp_resps[$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [127:0] ref_rline = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave: decides bus_ack/bus_rdata for the coming edge and checks each accepted beat.
  always @(negedge clk) begin
    int run;
    logic a;
    beat_t eb;
    run = bus_req ? req_run + 1 : 0;
    if (!bus_req && req_run != 0) last_run <= req_run;
    req_run <= run;
    case (ack_mode)
      M_RAND:  a = ($urandom_range(0, 2) == 0);
      M_DELAY: a = (run >= 4);
      M_NOB1:  a = (bus_addr[3:2] != 2'd1);
      default: a = 1'b1;
    endcase
    bus_ack   <= a;
    bus_rdata <= rd_pattern ? 32'hA0 + {30'b0, bus_addr[3:2]} : bus_rd(bus_addr);
    if (rst_n && bus_req && a) begin
      if (exp_beats.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat actual addr=%h we=%b required=no beat", bus_addr, bus_we);
      end else begin
        eb = exp_beats.pop_front();
        chk("beat_we", 128'(bus_we), 128'(eb.we));
        chk("beat_addr", 128'(bus_addr), 128'(eb.addr));
        if (eb.we) begin
          chk("beat_wdata", 128'(bus_wdata), 128'(eb.wdata));
          bus_mem[bus_addr] = bus_wdata;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    resp_t er;
    if (rst_n && main_mem_ack) begin
      ack_cnt <= ack_cnt + 1;
      last_ack_cyc <= cyc;
      if (exp_resps.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        er = exp_resps.pop_front();
        chk("m_r_data", m_r_data, er.line);
        chk("err", 128'(err), 128'(er.err));
      end
    end
  end

  task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [127:0] d,
                        input int hold, input bit pat, input bit tmo);
    resp_t er;
    beat_t b;
    logic [31:0] ak;
    int n, base, req_cyc;
    er.err = 1'b0;
    er.line = ref_rline;
    for (int k = 0; k < 4; k++) begin
      ak = {a[31:4], 4'b0} + 32'(k * 4);
      if (w) begin
        b.we = 1'b1; b.addr = ak; b.wdata = d[32*k +: 32];
        exp_beats.push_back(b);
        ref_mem[ak] = d[32*k +: 32];
      end else begin
        b.we = 1'b0; b.addr = ak; b.wdata = '0;
        if (!tmo || k == 0) exp_beats.push_back(b);
        if (!tmo || k == 0) er.line[32*k +: 32] = pat ? 32'hA0 + 32'(k) : ref_rd(ak);
      end
    end
    if (!w) begin
      er.err = tmo;
      ref_rline = er.line;
    end
    exp_resps.push_back(er);
    @(negedge clk); #1;
    mem_write = w; mem_read = r; m_addr = a; m_w_data = d;
    req_cyc = cyc; base = ack_cnt; n = 0;
    @(negedge clk); #1;
    // Request stays held; line inputs wander to prove they were latched.
    while (ack_cnt == base && n < 2000) begin
      m_addr = $urandom;
      m_w_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk); #1;
      n++;
    end
    if (ack_cnt == base) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=no ack required=ack addr=%h", a);
      exp_resps.delete(); exp_beats.delete();
    end
    if (pat) chk("latency", 128'(last_ack_cyc - req_cyc), 128'd8);
    repeat (hold) begin @(negedge clk); #1; end
    mem_write = 1'b0; mem_read = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit w, r;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 128'(bus_req), 0);
    chk("rst_bus_we", 128'(bus_we), 0);
    chk("rst_bus_addr", 128'(bus_addr), 0);
    chk("rst_bus_wdata", 128'(bus_wdata), 0);
    chk("rst_m_r_data", m_r_data, 0);
    chk("rst_ack", 128'(main_mem_ack), 0);
    chk("rst_err", 128'(err), 0);
    #1 rst_n = 1'b1;

    // Directed read with fixed pattern, minimum latency.
    ack_mode = M_ALWAYS; rd_pattern = 1'b1;
    do_req(0, 1, 32'h0000_1238, 128'h0, 0, 1, 0);
    chk("read_line_literal", m_r_data, 128'h000000A3_000000A2_000000A1_000000A0);
    rd_pattern = 1'b0;

    // Directed write-back with slow bus.
    ack_mode = M_DELAY;
    do_req(1, 0, 32'h0000_5670, 128'h44444444_33333333_22222222_11111111, 0, 0, 0);

    // Both requests high: write first, held after ack, then read back.
    ack_mode = M_RAND;
    do_req(1, 1, 32'h0000_5670, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 3, 0, 0);
    do_req(0, 1, 32'h0000_5674, 128'h0, 1, 0, 0);

    // Reset during beat 2 of a read.
    ack_mode = M_ALWAYS;
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.we = 1'b0; b.addr = 32'h2000 + 32'(k * 4); b.wdata = '0;
      exp_beats.push_back(b);
    end
    @(negedge clk); #1;
    mem_read = 1'b1; m_addr = 32'h0000_2000;
    n = 0;
    while (n < 50) begin
      @(negedge clk); #1;
      if (bus_req && bus_addr[3:2] == 2'd2) break;
      n++;
    end
    chk("reached_beat2", 128'(n < 50), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", 128'(bus_req), 0);
    chk("mid_rst_m_r_data", m_r_data, 0);
    chk("mid_rst_bus_addr", 128'(bus_addr), 0);
    chk("mid_rst_ack", 128'(main_mem_ack), 0);
    mem_read = 1'b0;
    exp_beats.delete();
    ref_rline = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    do_req(0, 1, 32'h0000_2000, 128'h0, 0, 0, 0);

`ifdef LINE_BRIDGE_TIMEOUT_EN
    ack_mode = M_NOB1;
    do_req(0, 1, 32'h0000_3000, 128'h0, 0, 0, 1);
    chk("timeout_req_cycles", 128'(last_run), 128'd256);
    ack_mode = M_ALWAYS;
    do_req(0, 1, 32'h0000_3010, 128'h0, 0, 0, 0);
`endif

    // Random traffic over a small set of lines so reads see earlier writes.
    for (int i = 0; i < 30; i++) begin
      ack_mode = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(w, r, 32'h0000_8000 | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15)),
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("beats_left", 128'(exp_beats.size()), 0);
    chk("resps_left", 128'(exp_resps.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
